// File: rtl/pe_result_collector.sv
// pe_result_collector: tags PE rounder results and queues them toward writeback.
// Ports: clk/rst_n, PE side (pe_data_in, pe_rounder_valid, pe_round_number,
// keep_out), stream side (out_valid/out_ready/out_data/out_tag), status
// (fifo_count, overflow_err). Optional PE_RESULT_COLLECTOR_STATS_EN adds
// result_cnt and drop_cnt.
module pe_result_collector #(
  parameter  int para_int_bits  = 7,
  parameter  int para_frac_bits = 9,
  parameter  int DEPTH          = 8,
  parameter  int KEEP_MARGIN    = 3,
  localparam int DATA_W = para_int_bits + para_frac_bits,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pe_data_in,
  input  logic              pe_rounder_valid,
  input  logic [3:0]        pe_round_number,
  output logic              keep_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_tag,
  output logic [CW-1:0]     fifo_count,
`ifdef PE_RESULT_COLLECTOR_STATS_EN
  output logic [15:0]       result_cnt,
  output logic [7:0]        drop_cnt,
`endif
  output logic              overflow_err
);

  logic              cap_valid;
  logic [3:0]        cap_tag;
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [3:0]        mem_tag  [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;
  logic              pop;
  logic              push_ok;
  logic              drop;

  assign out_valid  = (count != '0);
  assign out_data   = mem_data[rd_ptr];
  assign out_tag    = mem_tag[rd_ptr];
  assign fifo_count = count;

  assign pop     = out_valid && out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push_ok = cap_valid && ((count < CW'(DEPTH)) || pop);
  assign drop    = cap_valid && !push_ok;

  always_comb begin
    count_next = count;
    unique case (1'b1)
      push_ok && !pop: count_next = count + CW'(1);
      pop && !push_ok: count_next = count - CW'(1);
      default:         count_next = count;
    endcase
  end

  // Data arrives one cycle after its valid/tag, so tag is delayed to match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid    <= 1'b0;
      cap_tag      <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      keep_out     <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      cap_valid <= pe_rounder_valid;
      cap_tag   <= pe_round_number;
      count     <= count_next;
      // Margin absorbs results already inside the rounder pipeline.
      keep_out  <= (CW'(DEPTH) - count_next) <= CW'(KEEP_MARGIN);
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (drop)    overflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_tag[i]  <= '0;
      end
    end else if (push_ok) begin
      mem_data[wr_ptr] <= pe_data_in;
      mem_tag[wr_ptr]  <= cap_tag;
    end
  end

`ifdef PE_RESULT_COLLECTOR_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (push_ok && result_cnt != 16'hFFFF)
        result_cnt <= result_cnt + 16'd1;
      if (drop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_result_collector.sv
// tb_pe_result_collector: vector table, directed corner sequences and
// random traffic against a queue-based model of the collector.
module tb_pe_result_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pe_data_in = '0;
  logic        pe_rounder_valid = 1'b0;
  logic [3:0]  pe_round_number = '0;
  logic        keep_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [3:0]  out_tag;
  logic [3:0]  fifo_count;
  logic        overflow_err;
`ifdef PE_RESULT_COLLECTOR_STATS_EN
  logic [15:0] result_cnt;
  logic [7:0]  drop_cnt;
`endif

  pe_result_collector dut (
    .clk(clk),
    .rst_n(rst_n),
    .pe_data_in(pe_data_in),
    .pe_rounder_valid(pe_rounder_valid),
    .pe_round_number(pe_round_number),
    .keep_out(keep_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_tag(out_tag),
    .fifo_count(fifo_count),
`ifdef PE_RESULT_COLLECTOR_STATS_EN
    .result_cnt(result_cnt),
    .drop_cnt(drop_cnt),
`endif
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  t;
  } ent_t;

  ent_t     q[$];
  bit       pend_v;
  bit [3:0] pend_t;
  bit       ovf_m;
  int       acc_m;
  int       drop_m;
  int       n_chk;
  int       n_err;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    pend_v = 0;
    pend_t = '0;
    ovf_m  = 0;
    acc_m  = 0;
    drop_m = 0;
  endtask

  task automatic do_reset();
    pe_rounder_valid = 1'b0;
    pe_round_number  = '0;
    pe_data_in       = '0;
    out_ready        = 1'b0;
    rst_n            = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive at negedge, update model at the edge, return at negedge.
  task automatic step(input bit v, input logic [3:0] tg,
                      input logic [15:0] din, input bit rdy);
    bit pop_m;
    bit ok;
    pe_rounder_valid = v;
    pe_round_number  = tg;
    pe_data_in       = din;
    out_ready        = rdy;
    @(posedge clk);
    pop_m = (q.size() != 0) && rdy;
    ok    = pend_v && ((q.size() < 8) || pop_m);
    if (pop_m) void'(q.pop_front());
    if (ok) begin
      q.push_back(ent_t'{d: din, t: pend_t});
      acc_m++;
    end
    if (pend_v && !ok) begin
      ovf_m = 1;
      drop_m++;
    end
    pend_v = v;
    pend_t = tg;
    @(negedge clk);
  endtask

  task automatic check_model();
    check("valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("data", 32'(out_data), 32'(q[0].d));
      check("tag", 32'(out_tag), 32'(q[0].t));
    end
    check("count", 32'(fifo_count), 32'(q.size()));
    check("keep", 32'(keep_out), 32'((8 - q.size()) <= 3));
    check("ovf", 32'(overflow_err), 32'(ovf_m));
  endtask

  typedef struct {
    bit          v;
    logic [3:0]  tg;
    logic [15:0] d;
    bit          rdy;
    bit          ev;
    logic [15:0] ed;
    logic [3:0]  et;
    logic [3:0]  ec;
  } vec_t;

  vec_t tbl[7];

  initial begin
    n_chk = 0;
    n_err = 0;
    tbl[0] = '{1, 4'd3, 16'h0000, 1, 0, 16'h0000, 4'd0, 4'd0};
    tbl[1] = '{0, 4'd0, 16'h0A80, 1, 1, 16'h0A80, 4'd3, 4'd1};
    tbl[2] = '{0, 4'd0, 16'h0000, 1, 0, 16'h0000, 4'd0, 4'd0};
    tbl[3] = '{1, 4'd15, 16'h0000, 0, 0, 16'h0000, 4'd0, 4'd0};
    tbl[4] = '{0, 4'd0, 16'hFFFF, 0, 1, 16'hFFFF, 4'd15, 4'd1};
    tbl[5] = '{0, 4'd0, 16'h1234, 0, 1, 16'hFFFF, 4'd15, 4'd1};
    tbl[6] = '{0, 4'd0, 16'h0000, 1, 0, 16'h0000, 4'd0, 4'd0};

    do_reset();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_keep", 32'(keep_out), 0);
    check("rst_ovf", 32'(overflow_err), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_tag", 32'(out_tag), 0);

    for (int i = 0; i < 7; i++) begin
      step(tbl[i].v, tbl[i].tg, tbl[i].d, tbl[i].rdy);
      check("vec_valid", 32'(out_valid), 32'(tbl[i].ev));
      check("vec_count", 32'(fifo_count), 32'(tbl[i].ec));
      if (tbl[i].ev) begin
        check("vec_data", 32'(out_data), 32'(tbl[i].ed));
        check("vec_tag", 32'(out_tag), 32'(tbl[i].et));
      end
    end

    // Burst of 8, then one overflow, then ordered drain.
    do_reset();
    for (int i = 0; i <= 8; i++) begin
      step(i < 8, 4'(i), (i > 0) ? 16'(16'h0100 * i) : 16'h0, 0);
      check("burst_keep", 32'(keep_out), 32'(i >= 5));
      check_model();
    end
    check("burst_full", 32'(fifo_count), 8);
    step(1, 4'd5, 16'h0, 0);
    step(0, 4'd0, 16'hDEAD, 0);
    check("ovf_set", 32'(overflow_err), 1);
    check("ovf_count", 32'(fifo_count), 8);
    check_model();
    for (int i = 0; i < 8; i++) begin
      check("drain_tag", 32'(out_tag), 32'(i));
      check("drain_data", 32'(out_data), 32'(16'h0100 * (i + 1)));
      step(0, 4'd0, 16'h0, 1);
      check_model();
    end

    // Full with simultaneous push and pop.
    do_reset();
    for (int i = 0; i <= 8; i++)
      step(i < 8, 4'(i), 16'(16'h0100 * i), 0);
    step(1, 4'd2, 16'h0, 0);
    step(0, 4'd0, 16'h2222, 1);
    check("fullpp_count", 32'(fifo_count), 8);
    check("fullpp_ovf", 32'(overflow_err), 0);
    check_model();
    for (int i = 0; i < 8; i++) begin
      step(0, 4'd0, 16'h0, 1);
      check_model();
    end

    // Asynchronous reset with 5 stored and one capture pending.
    do_reset();
    for (int i = 0; i <= 5; i++)
      step(1, 4'(i), 16'(16'h0010 * i), 0);
    check("pre_rst_count", 32'(fifo_count), 5);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_count", 32'(fifo_count), 0);
    model_clear();
    pe_rounder_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 4'd0, 16'hBEEF, 0);
      check_model();
    end

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           16'($urandom), $urandom_range(0, 9) < 6);
      check_model();
    end

`ifdef PE_RESULT_COLLECTOR_STATS_EN
    do_reset();
    for (int i = 0; i <= 10; i++)
      step(i < 10, 4'(i), 16'(i), 0);
    step(1, 4'd1, 16'h0, 1);
    step(1, 4'd2, 16'h1, 1);
    step(0, 4'd0, 16'h2, 1);
    check("stat_result", 32'(result_cnt), 10);
    check("stat_drop", 32'(drop_cnt), 2);
    check("stat_model", 32'(result_cnt), 32'(acc_m));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
